cpu_mem_loader: RTL and testbench
=================================

Name: cpu_mem_loader

Overview:
Synthesizable successor to the bench-side memory preload/check flow. Streams words into any of N_CH external memory ports (imem, dmem, ...), reads back and compares against an expected stream, then runs the CPU and times it until the STOP opcode appears. Sits between a host/stream source and the cpu external-access ports (addr_ext/wen_ext/ren_ext/wdata_ext/rdata_ext, one set per channel) plus the cpu enable.

Parameters:
N_CH, 2, number of memory channels (ch 0 = imem, ch 1 = dmem by convention)
ADDR_W, 64, external address width
DATA_W, 32, external data width
CNT_W, 11, word-count width (max 2**CNT_W-1 words per command)
READ_LAT, 1, cycles from ren to valid rdata (>=1)
STOP_OPC, 7'b1111110, opcode field that marks end of program
TIMEOUT_CYCLES, 100000, RUN abort limit (used only with LOADER_TIMEOUT_EN)

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle command strobe, accepted only when busy=0
mode  in  2  00 LOAD, 01 VERIFY, 10 RUN, 11 reserved (ignored)
ch_sel  in  clog2(N_CH) (min 1)  target channel for LOAD/VERIFY
base_addr  in  ADDR_W  byte address of word 0
addr_shift  in  3  word i address = base_addr + (i << addr_shift)
word_cnt  in  CNT_W  words to transfer; 0 = complete immediately
s_valid  in  1  stream word valid
s_data  in  DATA_W  LOAD: write data; VERIFY: expected data
s_ready  out  1  stream word accepted when s_valid&s_ready
m_addr  out  N_CH*ADDR_W  per-channel address, channel k at [k*ADDR_W +: ADDR_W]
m_wen  out  N_CH  per-channel write enable
m_ren  out  N_CH  per-channel read enable
m_wdata  out  N_CH*DATA_W  per-channel write data
m_rdata  in  N_CH*DATA_W  per-channel read data
cpu_enable  out  1  cpu enable, high only in RUN
instr  in  32  cpu fetched instruction (observed)
busy  out  1  command in progress
done  out  1  held high from completion until next accepted start
mismatch_cnt  out  CNT_W  VERIFY mismatches (saturating)
first_err_idx  out  CNT_W  index of first mismatch
stop_code  out  4  instr[31:28] captured at STOP
cycle_cnt  out  32  RUN cycles from cpu_enable rise to STOP
timeout  out  1  RUN aborted by timeout

Behaviour:
- Reset: all outputs 0, state IDLE; counters, stop_code, error regs cleared. Reset mid-command aborts immediately; m_wen/m_ren/cpu_enable drop asynchronously.
- States: IDLE, LOAD, RD_ISSUE, RD_WAIT, CMP, RUN, DONE.
- IDLE: start with valid mode -> latch ch_sel, base, shift, count; clear done, idx, result regs (RUN clears cycle_cnt, stop_code, timeout; VERIFY clears mismatch_cnt, first_err_idx); busy=1 next cycle. word_cnt=0 on LOAD/VERIFY -> DONE. Reserved mode or start while busy: ignored.
- LOAD: s_ready=1; each handshake drives m_wen[ch]=1, m_addr, m_wdata for exactly that cycle (registered outputs), idx++. No handshake -> wen=0, idle wait. Last word -> DONE. Throughput 1 word/cycle.
- VERIFY: RD_ISSUE drives m_ren[ch]=1 one cycle at word address; RD_WAIT counts READ_LAT-1 further cycles; CMP asserts s_ready, waits for s_valid, compares m_rdata[ch] to s_data; mismatch -> mismatch_cnt++ (saturate at all-ones), first_err_idx=idx on first. Next word -> RD_ISSUE, last -> DONE. 2+READ_LAT-1 cycles/word minimum.
- Unselected channels: wen/ren 0, address/data 0.
- RUN: cpu_enable=1, cycle_cnt++ each cycle (saturating); when instr[6:0]==STOP_OPC sampled: stop_code=instr[31:28], cpu_enable=0 next cycle -> DONE. STOP present on entry cycle counts as cycle_cnt=1.
- DONE: done=1, busy=0, return to IDLE same cycle (done held).
- Address arithmetic modulo 2**ADDR_W (wrap, no error).

Optional Feature:
LOADER_TIMEOUT_EN: when defined, RUN aborts if cycle_cnt reaches TIMEOUT_CYCLES without STOP: timeout=1, stop_code=4'hF, cpu_enable=0, -> DONE. When undefined, timeout tied 0 and RUN waits indefinitely.

Test Plan:
- LOAD ch0, base 0, shift 2, 4 words 0x11,0x22,0x33,0x44 with s_valid gap after word 2 -> m_wen[0] pulses at addrs 0,4,8,12 with matching data, no pulse during gap, done after last, m_wen[1] never high.
- VERIFY ch1, shift 3, 3 words, memory model returns 5,6,7, expected 5,9,7 -> mismatch_cnt=1, first_err_idx=1, ren addrs 0,8,16.
- RUN with instr model issuing STOP 0x4000007E on 25th enabled cycle -> cycle_cnt=25, stop_code=4, cpu_enable low next cycle, done=1.
- word_cnt=0 LOAD -> done next cycle, no wen; start while busy -> ignored, counters unchanged.
- arst_n low mid-LOAD (word 2 of 8) -> wen/ren/busy/done 0 immediately; after release new LOAD of 1 word succeeds.
- With LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=50, no STOP -> timeout=1, stop_code=F, cycle_cnt=50; without macro, timeout stays 0.

Source files
------------

// File: rtl/cpu_mem_loader.sv
// cpu_mem_loader: streams words into per-channel CPU memory ports (LOAD),
// reads them back against an expected stream (VERIFY), and runs the CPU
// until the STOP opcode is fetched (RUN), counting the cycles it took.
// Optional feature macro: LOADER_TIMEOUT_EN (RUN abort after TIMEOUT_CYCLES).
module cpu_mem_loader #(
  parameter int unsigned N_CH           = 2,
  parameter int unsigned ADDR_W         = 64,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned CNT_W          = 11,
  parameter int unsigned READ_LAT       = 1,
  parameter logic [6:0]  STOP_OPC       = 7'b1111110,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  localparam int unsigned CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [CH_W-1:0]          ch_sel,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [2:0]               addr_shift,
  input  logic [CNT_W-1:0]         word_cnt,
  input  logic                     s_valid,
  input  logic [DATA_W-1:0]        s_data,
  output logic                     s_ready,
  output logic [N_CH*ADDR_W-1:0]   m_addr,
  output logic [N_CH-1:0]          m_wen,
  output logic [N_CH-1:0]          m_ren,
  output logic [N_CH*DATA_W-1:0]   m_wdata,
  input  logic [N_CH*DATA_W-1:0]   m_rdata,
  output logic                     cpu_enable,
  input  logic [31:0]              instr,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         mismatch_cnt,
  output logic [CNT_W-1:0]         first_err_idx,
  output logic [3:0]               stop_code,
  output logic [31:0]              cycle_cnt,
  output logic                     timeout
);

  localparam int unsigned WAIT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [1:0]  MODE_LOAD   = 2'b00;
  localparam logic [1:0]  MODE_VERIFY = 2'b01;
  localparam logic [1:0]  MODE_RUN    = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RD_ISSUE, S_RD_WAIT, S_CMP, S_RUN, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CH_W-1:0]      ch_q, ch_d;
  logic [ADDR_W-1:0]    base_q, base_d;
  logic [2:0]           shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     idx_q, idx_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 cmp_first_q, cmp_first_d;

  logic                     s_ready_d, cpu_enable_d, busy_d, done_d, timeout_d;
  logic [N_CH*ADDR_W-1:0]   m_addr_d;
  logic [N_CH-1:0]          m_wen_d, m_ren_d;
  logic [N_CH*DATA_W-1:0]   m_wdata_d;
  logic [CNT_W-1:0]         mismatch_d, first_err_d;
  logic [3:0]               stop_code_d;
  logic [31:0]              cycle_cnt_d, cyc_inc;

  logic                 wen_one, ren_one;
  logic [ADDR_W-1:0]    addr_val;
  logic [DATA_W-1:0]    wdata_val;
  logic [DATA_W-1:0]    rd_sel, rd_cur;
  logic                 last_word;

  // Only the opcode and stop-code fields of the fetched instruction matter.
  logic unused_instr;
  assign unused_instr = ^instr[27:7];

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] b,
                                                  input logic [CNT_W-1:0]  i,
                                                  input logic [2:0]        s);
    return b + (ADDR_W'(i) << s);
  endfunction

  // Read data of the latched channel.
  always_comb begin
    rd_sel = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (CH_W'(k) == ch_q) rd_sel = m_rdata[k*DATA_W +: DATA_W];
    end
  end

  // Read data is live on the first compare cycle, then held while the stream stalls.
  assign rd_cur    = cmp_first_q ? rd_sel : rdata_q;
  assign last_word = (idx_q == cnt_q - CNT_W'(1));

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    base_d       = base_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    wait_d       = wait_q;
    rdata_d      = rdata_q;
    done_d       = done;
    mismatch_d   = mismatch_cnt;
    first_err_d  = first_err_idx;
    stop_code_d  = stop_code;
    cycle_cnt_d  = cycle_cnt;
    timeout_d    = timeout;
    wen_one      = 1'b0;
    ren_one      = 1'b0;
    addr_val     = '0;
    wdata_val    = '0;
    m_addr_d     = '0;
    m_wen_d      = '0;
    m_ren_d      = '0;
    m_wdata_d    = '0;
    cyc_inc      = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + 32'd1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && mode != 2'b11) begin
          ch_d    = ch_sel;
          base_d  = base_addr;
          shift_d = addr_shift;
          cnt_d   = word_cnt;
          idx_d   = '0;
          done_d  = 1'b0;
          case (mode)
            MODE_LOAD: state_d = (word_cnt == '0) ? S_DONE : S_LOAD;
            MODE_VERIFY: begin
              mismatch_d  = '0;
              first_err_d = '0;
              if (word_cnt == '0) begin
                state_d = S_DONE;
              end else begin
                state_d  = S_RD_ISSUE;
                ren_one  = 1'b1;
                addr_val = base_addr;
              end
            end
            MODE_RUN: begin
              cycle_cnt_d = '0;
              stop_code_d = '0;
              timeout_d   = 1'b0;
              state_d     = S_RUN;
            end
            default: state_d = state_q;
          endcase
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (s_valid) begin
          wen_one   = 1'b1;
          addr_val  = word_addr(base_q, idx_q, shift_q);
          wdata_val = s_data;
          idx_d     = idx_q + CNT_W'(1);
          if (last_word) state_d = S_DONE;
        end
      end
      S_RD_ISSUE: begin
        wait_d  = '0;
        state_d = (READ_LAT > 1) ? S_RD_WAIT : S_CMP;
      end
      S_RD_WAIT: begin
        if (wait_q == WAIT_W'(READ_LAT - 2)) state_d = S_CMP;
        else                                 wait_d  = wait_q + WAIT_W'(1);
      end
      S_CMP: begin
        rdata_d = rd_cur;
        if (s_valid) begin
          if (rd_cur != s_data) begin
            if (mismatch_cnt == '0) first_err_d = idx_q;
            if (mismatch_cnt != '1) mismatch_d  = mismatch_cnt + CNT_W'(1);
          end
          if (last_word) begin
            state_d = S_DONE;
          end else begin
            idx_d    = idx_q + CNT_W'(1);
            state_d  = S_RD_ISSUE;
            ren_one  = 1'b1;
            addr_val = word_addr(base_q, idx_q + CNT_W'(1), shift_q);
          end
        end
      end
      S_RUN: begin
        cycle_cnt_d = cyc_inc;
        if (instr[6:0] == STOP_OPC) begin
          stop_code_d = instr[31:28];
          state_d     = S_DONE;
        end
`ifdef LOADER_TIMEOUT_EN
        else if (cyc_inc == 32'(TIMEOUT_CYCLES)) begin
          timeout_d   = 1'b1;
          stop_code_d = 4'hF;
          state_d     = S_DONE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

`ifndef LOADER_TIMEOUT_EN
    timeout_d = 1'b0;
`endif

    if (state_d == S_DONE) done_d = 1'b1;
    cpu_enable_d = (state_d == S_RUN);
    busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
    s_ready_d    = (state_d == S_LOAD) || (state_d == S_CMP);
    cmp_first_d  = (state_d == S_CMP) && (state_q != S_CMP);

    for (int unsigned k = 0; k < N_CH; k++) begin
      if (CH_W'(k) == ch_d) begin
        m_wen_d[k] = wen_one;
        m_ren_d[k] = ren_one;
        if (wen_one || ren_one) m_addr_d[k*ADDR_W +: ADDR_W] = addr_val;
        if (wen_one)            m_wdata_d[k*DATA_W +: DATA_W] = wdata_val;
      end
    end
  end

  // State, context and registered outputs; reset drops strobes immediately.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q       <= S_IDLE;
      ch_q          <= '0;
      base_q        <= '0;
      shift_q       <= '0;
      cnt_q         <= '0;
      idx_q         <= '0;
      wait_q        <= '0;
      rdata_q       <= '0;
      cmp_first_q   <= 1'b0;
      s_ready       <= 1'b0;
      m_addr        <= '0;
      m_wen         <= '0;
      m_ren         <= '0;
      m_wdata       <= '0;
      cpu_enable    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      mismatch_cnt  <= '0;
      first_err_idx <= '0;
      stop_code     <= '0;
      cycle_cnt     <= '0;
      timeout       <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      base_q        <= base_d;
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      wait_q        <= wait_d;
      rdata_q       <= rdata_d;
      cmp_first_q   <= cmp_first_d;
      s_ready       <= s_ready_d;
      m_addr        <= m_addr_d;
      m_wen         <= m_wen_d;
      m_ren         <= m_ren_d;
      m_wdata       <= m_wdata_d;
      cpu_enable    <= cpu_enable_d;
      busy          <= busy_d;
      done          <= done_d;
      mismatch_cnt  <= mismatch_d;
      first_err_idx <= first_err_d;
      stop_code     <= stop_code_d;
      cycle_cnt     <= cycle_cnt_d;
      timeout       <= timeout_d;
    end
  end

endmodule

// File: tb/tb_cpu_mem_loader.sv
// Directed bench for cpu_mem_loader: LOAD, VERIFY, RUN, zero-length and
// ignored commands, mid-command reset. With LOADER_TIMEOUT_EN defined the
// RUN abort path is exercised, otherwise timeout must stay low.
module tb_cpu_mem_loader;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] STOP = 32'h4000_007E;

  logic         clk;
  logic         arst_n;
  logic         start;
  logic [1:0]   mode;
  logic [0:0]   ch_sel;
  logic [63:0]  base_addr;
  logic [2:0]   addr_shift;
  logic [10:0]  word_cnt;
  logic         s_valid;
  logic [31:0]  s_data;
  logic         s_ready;
  logic [127:0] m_addr;
  logic [1:0]   m_wen;
  logic [1:0]   m_ren;
  logic [63:0]  m_wdata;
  logic [63:0]  m_rdata;
  logic         cpu_enable;
  logic [31:0]  instr;
  logic         busy;
  logic         done;
  logic [10:0]  mismatch_cnt;
  logic [10:0]  first_err_idx;
  logic [3:0]   stop_code;
  logic [31:0]  cycle_cnt;
  logic         timeout;

  logic [31:0]  mem1 [4];
  logic [31:0]  rdata_ch1;
  int           checks;
  int           errors;

  cpu_mem_loader #(
    .N_CH(2), .ADDR_W(64), .DATA_W(32), .CNT_W(11), .READ_LAT(1),
    .STOP_OPC(7'b1111110), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .arst_n(arst_n), .start(start), .mode(mode), .ch_sel(ch_sel),
    .base_addr(base_addr), .addr_shift(addr_shift), .word_cnt(word_cnt),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_addr(m_addr), .m_wen(m_wen), .m_ren(m_ren), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .cpu_enable(cpu_enable), .instr(instr),
    .busy(busy), .done(done), .mismatch_cnt(mismatch_cnt),
    .first_err_idx(first_err_idx), .stop_code(stop_code),
    .cycle_cnt(cycle_cnt), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ch1 memory: one-cycle read latency, word index = address bits [4:3].
  always @(posedge clk) begin
    if (m_ren[1]) rdata_ch1 <= mem1[m_addr[67 +: 2]];
  end
  // ch0 returns a fixed pattern so reading the wrong channel shows up.
  assign m_rdata = {rdata_ch1, 32'hDEAD_BEEF};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue a command at a negedge; returns at the next negedge.
  task automatic cmd(input logic [1:0] md, input logic cs, input logic [63:0] ba,
                     input logic [2:0] sh, input logic [10:0] wc);
    mode = md; ch_sel = cs; base_addr = ba; addr_shift = sh; word_cnt = wc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] vexp [3];
    logic [63:0] vaddr [3];
    checks = 0; errors = 0;
    arst_n = 1'b0; start = 1'b0; mode = 2'b00; ch_sel = 1'b0; base_addr = '0;
    addr_shift = '0; word_cnt = '0; s_valid = 1'b0; s_data = '0; instr = NOP;
    rdata_ch1 = '0;
    mem1[0] = 32'd5; mem1[1] = 32'd6; mem1[2] = 32'd7; mem1[3] = 32'd0;
    vexp[0] = 32'd5; vexp[1] = 32'd9; vexp[2] = 32'd7;
    vaddr[0] = 64'd0; vaddr[1] = 64'd8; vaddr[2] = 64'd16;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_strobes", 128'({m_wen, m_ren, cpu_enable, s_ready}), 128'(0));
    chk("rst_cnts", 128'({cycle_cnt, mismatch_cnt, stop_code}), 128'(0));
    arst_n = 1'b1;
    @(negedge clk);

    // LOAD ch0, shift 2, four words with a valid gap after word 2
    cmd(2'b00, 1'b0, 64'd0, 3'd2, 11'd4);
    chk("load_ready", 128'({busy, done, s_ready}), 128'(3'b101));
    s_valid = 1'b1; s_data = 32'h11; @(negedge clk);
    chk("load_w0", {m_addr, m_wdata, m_wen}, {64'd0, 64'd0, 32'd0, 32'h11, 2'b01});
    s_data = 32'h22; @(negedge clk);
    chk("load_w1", {m_addr, m_wdata, m_wen}, {64'd0, 64'd4, 32'd0, 32'h22, 2'b01});
    s_valid = 1'b0; @(negedge clk);
    chk("load_gap", 128'({m_wen, busy, done}), 128'(4'b0010));
    s_valid = 1'b1; s_data = 32'h33; @(negedge clk);
    chk("load_w2", {m_addr, m_wdata, m_wen}, {64'd0, 64'd8, 32'd0, 32'h33, 2'b01});
    s_data = 32'h44; @(negedge clk);
    chk("load_w3", {m_addr, m_wdata, m_wen}, {64'd0, 64'd12, 32'd0, 32'h44, 2'b01});
    chk("load_done", 128'({busy, done, s_ready}), 128'(3'b010));
    s_valid = 1'b0; @(negedge clk);
    chk("load_after", 128'({m_wen, done}), 128'(3'b001));

    // VERIFY ch1, shift 3: memory 5,6,7 vs expected 5,9,7
    cmd(2'b01, 1'b1, 64'd0, 3'd3, 11'd3);
    for (int w = 0; w < 3; w++) begin
      chk("vfy_ren", {m_addr, m_ren}, {vaddr[w], 64'd0, 2'b10});
      s_valid = 1'b0; @(negedge clk);
      if (w == 1) @(negedge clk);
      chk("vfy_ready", 128'({s_ready, m_ren}), 128'(3'b100));
      s_valid = 1'b1; s_data = vexp[w]; @(negedge clk);
    end
    s_valid = 1'b0;
    chk("vfy_done", 128'({busy, done}), 128'(2'b01));
    chk("vfy_mismatch", 128'(mismatch_cnt), 128'(1));
    chk("vfy_first_err", 128'(first_err_idx), 128'(1));

    // RUN: STOP on the 25th enabled cycle
    cmd(2'b10, 1'b0, 64'd0, 3'd0, 11'd0);
    chk("run_entry", 128'({cpu_enable, busy, done}), 128'(3'b110));
    for (int i = 0; i < 25; i++) begin
      if (i == 24) chk("run_en_last", 128'(cpu_enable), 128'(1));
      instr = (i == 24) ? STOP : NOP;
      @(negedge clk);
    end
    instr = NOP;
    chk("run_stop", 128'({cpu_enable, busy, done}), 128'(3'b001));
    chk("run_cycles", 128'(cycle_cnt), 128'(25));
    chk("run_code", 128'({timeout, stop_code}), 128'(5'h04));
    chk("run_keeps_vfy", 128'(mismatch_cnt), 128'(1));

    // Zero-length LOAD completes at once with no write
    cmd(2'b00, 1'b0, 64'd0, 3'd0, 11'd0);
    chk("zero_load", 128'({m_wen, busy, done}), 128'(4'b0001));

    // Start while busy is ignored
    cmd(2'b00, 1'b0, 64'd0, 3'd0, 11'd2);
    cmd(2'b01, 1'b1, 64'd0, 3'd0, 11'd5);
    chk("busy_ignore", 128'({busy, s_ready, m_ren}), 128'(4'b1100));
    chk("busy_ignore_cnt", 128'(mismatch_cnt), 128'(1));
    s_valid = 1'b1; s_data = 32'hA; @(negedge clk);
    s_data = 32'hB; @(negedge clk);
    s_valid = 1'b0;
    chk("busy_load_end", {m_addr, m_wdata, m_wen}, {64'd0, 64'd1, 32'd0, 32'hB, 2'b01});
    chk("busy_load_done", 128'({busy, done}), 128'(2'b01));

`ifdef LOADER_TIMEOUT_EN
    // RUN without STOP aborts after 50 cycles
    cmd(2'b10, 1'b0, 64'd0, 3'd0, 11'd0);
    repeat (49) @(negedge clk);
    chk("tmo_pre", 128'({cpu_enable, timeout}), 128'(2'b10));
    @(negedge clk);
    chk("tmo_flag", 128'({cpu_enable, timeout, done}), 128'(3'b011));
    chk("tmo_code", 128'(stop_code), 128'(4'hF));
    chk("tmo_cycles", 128'(cycle_cnt), 128'(50));
`else
    // RUN without STOP keeps waiting, never times out
    cmd(2'b10, 1'b0, 64'd0, 3'd0, 11'd0);
    repeat (60) @(negedge clk);
    chk("notmo_wait", 128'({cpu_enable, busy, timeout}), 128'(3'b110));
    instr = STOP; @(negedge clk);
    instr = NOP;
    chk("notmo_stop", 128'({timeout, done}), 128'(2'b01));
    chk("notmo_cycles", 128'(cycle_cnt), 128'(61));
`endif

    // Reset in the middle of an 8-word LOAD
    cmd(2'b00, 1'b0, 64'h40, 3'd2, 11'd8);
    s_valid = 1'b1; s_data = 32'hA0; @(negedge clk);
    s_data = 32'hA1; @(negedge clk);
    chk("mid_wen", 128'({m_wen, busy}), 128'(3'b011));
    arst_n = 1'b0;
    #1;
    chk("mid_rst", 128'({m_wen, m_ren, busy, done, s_ready, cpu_enable}), 128'(0));
    s_valid = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    cmd(2'b00, 1'b1, 64'h100, 3'd0, 11'd1);
    s_valid = 1'b1; s_data = 32'hC; @(negedge clk);
    s_valid = 1'b0;
    chk("post_rst_load", {m_addr, m_wdata, m_wen}, {64'h100, 64'd0, 32'hC, 32'd0, 2'b10});
    chk("post_rst_done", 128'({busy, done, mismatch_cnt}), 128'({2'b01, 11'd0}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
